// File: rtl/tx_serializer_if.sv
// Flit handoff between the router side and tx_serializer: valid/data in, item_read back.
interface tx_serializer_if #(
  parameter int SIZE = 8
);
  logic            valid;
  logic [SIZE-1:0] parallel_in;
  logic            item_read;

  modport master (output valid, output parallel_in, input item_read);
  modport slave  (input valid, input parallel_in, output item_read);
endinterface

// File: rtl/tx_serializer.sv
// Buffers parallel flits in a small FIFO and shifts each onto a 1-bit link as
// start bit, SIZE data bits LSB first, trailer 0; waits for channel_busy low to launch.
module tx_serializer #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  tx_serializer_if.slave   in_if,
  input  logic             channel_busy,
  output logic             serial_out,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SIZE);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_TRAIL} state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic             serial_q, serial_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SIZE-1:0]  mem [DEPTH];
  logic             push;
  logic             pop;

  // Full blocks acceptance even on an edge that also pops.
  assign push            = in_if.valid & (count_q < FULL) & reset;
  assign in_if.item_read = push;
  assign serial_out      = serial_q;
  assign empty           = (count_q == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_if.parallel_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    serial_d = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !channel_busy) begin
          shreg_d  = mem[rd_ptr_q];
          pop      = 1'b1;
          serial_d = 1'b1;
          bitcnt_d = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        // bitcnt reaching SIZE means the last data bit is already on the line.
        if (bitcnt_q == LAST_BIT) begin
          serial_d = 1'b0;
          state_d  = S_TRAIL;
        end else begin
          serial_d = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + BIT_W'(1);
        end
      end
      S_TRAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      serial_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      serial_q <= serial_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: doc/tx_serializer.md
# tx_serializer

Upstream companion of the network's serial receiver: it buffers parallel flits from the router side and shifts each one onto a 1-bit link. The framing is chosen so the receiver rebuilds the flit exactly. The block contains a small FIFO, a 3-state serializer FSM and a valid/item_read handshake on its input. It waits for the receiver's `channel_busy` to clear before starting each frame.

## Interface
- `SIZE`, 8, flit width in bits; equals the network-wide flit width.
- `DEPTH`, 4, input FIFO entries; power of two, >= 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `valid`  in  1  upstream presents a flit on `parallel_in`; data held stable until accepted.
- `parallel_in`  in  SIZE  flit to transmit.
- `item_read`  out  1  combinational; `valid & (count < DEPTH) & reset`. The flit is accepted on the rising edge where this is 1.
- `channel_busy`  in  1  receiver not idle; the next frame may not start while it is 1.
- `serial_out`  out  1  registered serial line to the receiver.
- `empty`  out  1  FIFO holds no flits; the FSM state is not included.

## Operation
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH; count is 0..DEPTH.
  - Push when `item_read` is 1.
  - Pop when the FSM launches a frame.
  - Push and pop on the same edge are allowed (count unchanged).
  - When full, `item_read` = 0 even if a pop occurs that edge.
- Frame on `serial_out`, SIZE+2 cycles: start bit 1, then SIZE data bits LSB first, then one trailer cycle of 0. The line is 0 whenever not framing.
- FSM states:
  - IDLE: `serial_out` 0.
    - If count > 0 and `channel_busy` = 0: load the FIFO head into the shift register, pop, drive `serial_out` <= 1, clear the bit counter, go to SEND.
    - Otherwise stay in IDLE.
  - SEND: each edge, `serial_out` <= shreg[0], shreg >>= 1, bitcnt++.
    - After the edge that drives data bit SIZE-1, the next edge drives `serial_out` <= 0 and goes to TRAIL.
  - TRAIL: one cycle with the line at 0, then IDLE unconditionally.
- `channel_busy` is ignored in SEND and TRAIL. The receiver reports busy from the cycle after the start bit through delivery of the flit.
- Reset assertion, including mid-frame:
  - `serial_out` goes to 0 immediately.
  - FSM goes to IDLE; pointers and count clear, discarding all buffered flits.
  - Any partial frame is abandoned; the receiver must be reset in the same event.

## Timing
- Reset values: `serial_out` 0, `empty` 1, `item_read` 0 (while reset is asserted), state IDLE, count 0.
- Latency: a flit accepted at edge A into an empty FIFO, with IDLE and `channel_busy` = 0, has its start bit driven at edge A+1.
- Frame edges, with the start bit driven at edge E0:
  - Data bit k (k = 0..SIZE-1) is driven at edge E(k+1).
  - The trailer is driven at edge E(SIZE+1).
  - The FSM is back in IDLE at edge E(SIZE+2).
- Earliest next start: the first edge in IDLE where count > 0 and `channel_busy` is sampled 0.
  - The receiver holds busy high from E(SIZE+2) until its flit is read, so there is no overlap race.
- Throughput: at most one flit per SIZE+3 cycles, limited further by receiver drain.
- `empty` and `item_read` reflect count after the most recent edge.

## Test plan
- Reset, then push 8'hA5 with `channel_busy` = 0 -> `item_read` high for 1 cycle. `serial_out` starting one edge later: 1, 1,0,1,0,0,1,0,1, 0, then stays 0; `empty` = 1 after the start edge.
- Loopback to the receiver model; push 8'h01, 8'h80, 8'hFF, 8'h00 back to back; the receiver-side consumer reads each flit one cycle after valid -> receiver delivers 01, 80, FF, 00 in order, with no frame starting while `channel_busy` = 1.
- DEPTH=4, `channel_busy` held 1, push 5 flits -> `item_read` 1 for the first 4 and 0 for the 5th; `serial_out` stays 0; `empty` = 0. Release busy -> start bit next edge, and the 5th flit is accepted on the edge after the pop.
- Count = 1, FSM launching a frame while `valid` = 1 -> push and pop on the same edge, count stays 1, and the new flit is framed after the current one.
- Assert reset during data bit 3 of 8'h3C -> `serial_out` 0 immediately, `empty` 1, `item_read` 0. After release, push 8'h5A -> a clean frame: 1, 0,1,0,1,1,0,1,0, 0.
- `channel_busy` toggling 1/0 every cycle while IDLE with data queued -> start only on an edge where busy is sampled 0; frame length is exactly SIZE+2 regardless of busy during SEND/TRAIL.
